// File: rtl/debug_trace_buffer_pkg.sv
// Shared types for the commit-trace buffer: one captured register-file write.
package debug_trace_params;

  typedef struct packed {
    logic [31:0] program_count;
    logic [3:0]  write_strobe;
    logic [4:0]  write_address;
    logic [31:0] write_data;
  } TraceEntry;

  localparam int TRACE_ENTRY_WIDTH = $bits(TraceEntry);

endpackage

// File: rtl/debug_trace_buffer_if.sv
// Capture-side and consumer-side signals of the trace buffer.
// The master modport is the buffer's view; slave is the view of the core and consumer.
interface debug_trace_buffer_if #(
  parameter int DEPTH      = 16,
  parameter int DROP_WIDTH = 16
);

  logic [31:0]            debug_program_count;
  logic [3:0]             debug_register_file_write_enabled;
  logic [4:0]             debug_register_file_write_address;
  logic [31:0]            debug_register_file_write_data;
  logic                   capture_enabled;
  logic                   trace_valid;
  logic                   trace_ready;
  logic [31:0]            trace_program_count;
  logic [3:0]             trace_write_strobe;
  logic [4:0]             trace_write_address;
  logic [31:0]            trace_write_data;
  logic [$clog2(DEPTH):0] trace_count;
  logic                   trace_overflow;
  logic [DROP_WIDTH-1:0]  dropped_count;
  logic                   overflow_clear;

  modport master (
    input  debug_program_count, debug_register_file_write_enabled,
           debug_register_file_write_address, debug_register_file_write_data,
           capture_enabled, trace_ready, overflow_clear,
    output trace_valid, trace_program_count, trace_write_strobe,
           trace_write_address, trace_write_data, trace_count,
           trace_overflow, dropped_count
  );

  modport slave (
    output debug_program_count, debug_register_file_write_enabled,
           debug_register_file_write_address, debug_register_file_write_data,
           capture_enabled, trace_ready, overflow_clear,
    input  trace_valid, trace_program_count, trace_write_strobe,
           trace_write_address, trace_write_data, trace_count,
           trace_overflow, dropped_count
  );

endinterface

// File: rtl/debug_trace_buffer_storage.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Deliberately not reset; contents are only meaningful once written.
module trace_fifo_storage
  import debug_trace_params::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          write_enable,
  input  logic [AW-1:0] write_pointer,
  input  TraceEntry     write_entry,
  input  logic [AW-1:0] read_pointer,
  output TraceEntry     read_entry
);

  logic [TRACE_ENTRY_WIDTH-1:0] mem_r [DEPTH];

  // Write port: a slot changes only on an accepted push.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem_r[write_pointer] <= write_entry;
    end
  end

  assign read_entry = TraceEntry'(mem_r[read_pointer]);

endmodule

// File: rtl/debug_trace_buffer.sv
// FIFO of retired register-file writes with a valid/ready drain port and
// a sticky overflow flag plus saturating dropped-entry counter.
module debug_trace_buffer
  import debug_trace_params::*;
#(
  parameter int DEPTH      = 16,
  parameter int DROP_WIDTH = 16
) (
  input logic                clock,
  input logic                reset,
  debug_trace_buffer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]         write_pointer_r;
  logic [AW-1:0]         read_pointer_r;
  logic [CW-1:0]         count_r;
  logic                  valid_r;
  logic                  overflow_r;
  logic [DROP_WIDTH-1:0] dropped_r;

  logic                  capture_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [CW-1:0]         count_next_s;
  logic                  overflow_next_s;
  logic [DROP_WIDTH-1:0] dropped_next_s;
  TraceEntry             write_entry_s;
  TraceEntry             read_entry_s;

  function automatic logic [DROP_WIDTH-1:0] saturating_increment(
    input logic [DROP_WIDTH-1:0] value
  );
    if (value == {DROP_WIDTH{1'b1}}) begin
      return value;
    end else begin
      return value + DROP_WIDTH'(1);
    end
  endfunction

  assign capture_s = bus.capture_enabled
                   & (bus.debug_register_file_write_enabled != 4'b0000)
                   & (bus.debug_register_file_write_address != 5'd0);
  assign full_s    = (count_r == FULL_COUNT);
  assign pop_s     = valid_r & bus.trace_ready;
  // A pop on a full FIFO frees the slot this cycle, so the capture still lands.
  assign push_s    = capture_s & (~full_s | pop_s);
  assign drop_s    = capture_s & full_s & ~pop_s;

  assign write_entry_s = '{
    program_count: bus.debug_program_count,
    write_strobe:  bus.debug_register_file_write_enabled,
    write_address: bus.debug_register_file_write_address,
    write_data:    bus.debug_register_file_write_data
  };

  trace_fifo_storage #(.DEPTH(DEPTH)) u_storage (
    .clock         (clock),
    .write_enable  (push_s),
    .write_pointer (write_pointer_r),
    .write_entry   (write_entry_s),
    .read_pointer  (read_pointer_r),
    .read_entry    (read_entry_s)
  );

  // Next occupancy and overflow bookkeeping; a drop outranks a same-cycle clear.
  always_comb begin
    count_next_s    = count_r;
    overflow_next_s = overflow_r;
    dropped_next_s  = dropped_r;

    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase

    if (drop_s) begin
      overflow_next_s = 1'b1;
      if (bus.overflow_clear) begin
        dropped_next_s = DROP_WIDTH'(1);
      end else begin
        dropped_next_s = saturating_increment(dropped_r);
      end
    end else if (bus.overflow_clear) begin
      overflow_next_s = 1'b0;
      dropped_next_s  = {DROP_WIDTH{1'b0}};
    end else begin
      overflow_next_s = overflow_r;
      dropped_next_s  = dropped_r;
    end
  end

  // Pointer, occupancy, valid and overflow registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_pointer_r <= {AW{1'b0}};
      read_pointer_r  <= {AW{1'b0}};
      count_r         <= {CW{1'b0}};
      valid_r         <= 1'b0;
      overflow_r      <= 1'b0;
      dropped_r       <= {DROP_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        write_pointer_r <= write_pointer_r + AW'(1);
      end
      if (pop_s) begin
        read_pointer_r <= read_pointer_r + AW'(1);
      end
      count_r    <= count_next_s;
      valid_r    <= (count_next_s != {CW{1'b0}});
      overflow_r <= overflow_next_s;
      dropped_r  <= dropped_next_s;
    end
  end

  assign bus.trace_valid         = valid_r;
  assign bus.trace_program_count = read_entry_s.program_count;
  assign bus.trace_write_strobe  = read_entry_s.write_strobe;
  assign bus.trace_write_address = read_entry_s.write_address;
  assign bus.trace_write_data    = read_entry_s.write_data;
  assign bus.trace_count         = count_r;
  assign bus.trace_overflow      = overflow_r;
  assign bus.dropped_count       = dropped_r;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer: expected entries go into a queue at
// capture time and a negedge monitor checks every accepted handshake against it.
module tb_debug_trace_buffer;
  import debug_trace_params::*;

  localparam int DEPTH      = 16;
  localparam int DROP_WIDTH = 16;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  TraceEntry sb_q[$];

  debug_trace_buffer_if #(.DEPTH(DEPTH), .DROP_WIDTH(DROP_WIDTH)) bus ();

  debug_trace_buffer #(.DEPTH(DEPTH), .DROP_WIDTH(DROP_WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input logic [31:0] pc, input logic [3:0] strb, input logic [4:0] addr,
                         input logic [31:0] data, input bit kept);
    bus.debug_program_count               = pc;
    bus.debug_register_file_write_enabled = strb;
    bus.debug_register_file_write_address = addr;
    bus.debug_register_file_write_data    = data;
    if (kept) sb_q.push_back({pc, strb, addr, data});
    step();
    bus.debug_register_file_write_enabled = 4'h0;
  endtask

  // Monitor: every handshake the DUT will accept at the next edge is checked.
  always @(negedge clock) begin
    TraceEntry got;
    TraceEntry exp;
    if (reset === 1'b0 && bus.trace_valid === 1'b1 && bus.trace_ready === 1'b1) begin
      got = {bus.trace_program_count, bus.trace_write_strobe,
             bus.trace_write_address, bus.trace_write_data};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%h expected=none", got);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pop_entry actual=%h expected=%h", got, exp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.capture_enabled                   = 1'b1;
    bus.debug_program_count               = 32'h0;
    bus.debug_register_file_write_enabled = 4'h0;
    bus.debug_register_file_write_address = 5'd0;
    bus.debug_register_file_write_data    = 32'h0;
    bus.trace_ready                       = 1'b0;
    bus.overflow_clear                    = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    check("reset_valid", bus.trace_valid, 32'd0);
    check("reset_count", bus.trace_count, 32'd0);
    check("reset_overflow", bus.trace_overflow, 32'd0);
    check("reset_dropped", bus.dropped_count, 32'd0);

    // Single capture, visible one cycle later, then popped.
    capture(32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678, 1'b1);
    check("single_valid", bus.trace_valid, 32'd1);
    check("single_count", bus.trace_count, 32'd1);
    check("single_pc", bus.trace_program_count, 32'hBFC0_0000);
    check("single_strobe", bus.trace_write_strobe, 32'hF);
    check("single_addr", bus.trace_write_address, 32'd8);
    check("single_data", bus.trace_write_data, 32'h1234_5678);
    bus.trace_ready = 1'b1;
    step();
    bus.trace_ready = 1'b0;
    check("single_pop_valid", bus.trace_valid, 32'd0);
    check("single_pop_count", bus.trace_count, 32'd0);

    // Filtering.
    capture(32'h0000_0100, 4'hF, 5'd0, 32'h1, 1'b0);
    check("filter_addr0_count", bus.trace_count, 32'd0);
    capture(32'h0000_0104, 4'h0, 5'd3, 32'h2, 1'b0);
    check("filter_strobe0_count", bus.trace_count, 32'd0);
    bus.capture_enabled = 1'b0;
    capture(32'h0000_0108, 4'hF, 5'd3, 32'h3, 1'b0);
    bus.capture_enabled = 1'b1;
    check("filter_disabled_count", bus.trace_count, 32'd0);
    check("filter_disabled_valid", bus.trace_valid, 32'd0);

    // Overflow: 18 captures into 16 slots.
    for (int i = 0; i < 18; i++) begin
      capture(32'(32'h8000_0000 + 4 * i), 4'(1 << (i % 4)), 5'(i + 1),
              32'(32'hA000_0000 + i), (i < 16));
    end
    check("ovf_count", bus.trace_count, 32'd16);
    check("ovf_flag", bus.trace_overflow, 32'd1);
    check("ovf_dropped", bus.dropped_count, 32'd2);
    check("ovf_valid", bus.trace_valid, 32'd1);
    bus.capture_enabled = 1'b0;
    capture(32'h0000_0200, 4'hF, 5'd4, 32'h4, 1'b0);
    bus.capture_enabled = 1'b1;
    check("full_disabled_dropped", bus.dropped_count, 32'd2);
    check("full_disabled_count", bus.trace_count, 32'd16);

    // Full with simultaneous push and pop: nothing dropped, new entry last.
    bus.trace_ready = 1'b1;
    capture(32'hC0DE_0000, 4'hF, 5'd31, 32'hFEED_F00D, 1'b1);
    bus.trace_ready = 1'b0;
    check("pushpop_count", bus.trace_count, 32'd16);
    check("pushpop_dropped", bus.dropped_count, 32'd2);
    bus.trace_ready = 1'b1;
    repeat (16) step();
    bus.trace_ready = 1'b0;
    check("drain_count", bus.trace_count, 32'd0);
    check("drain_valid", bus.trace_valid, 32'd0);
    check("drain_queue_empty", sb_q.size(), 32'd0);

    // Clear, then build dropped_count = 5, then race a clear against a drop.
    bus.overflow_clear = 1'b1;
    step();
    bus.overflow_clear = 1'b0;
    check("clear_flag", bus.trace_overflow, 32'd0);
    check("clear_dropped", bus.dropped_count, 32'd0);
    for (int i = 0; i < 21; i++) begin
      capture(32'(32'h9000_0000 + 4 * i), 4'hF, 5'(i % 31 + 1),
              32'(32'h5000_0000 + i), (i < 16));
    end
    check("five_dropped", bus.dropped_count, 32'd5);
    check("five_flag", bus.trace_overflow, 32'd1);
    bus.overflow_clear = 1'b1;
    capture(32'h9000_1000, 4'hF, 5'd9, 32'h6, 1'b0);
    bus.overflow_clear = 1'b0;
    check("race_flag", bus.trace_overflow, 32'd1);
    check("race_dropped", bus.dropped_count, 32'd1);

    // Saturation: hold a capture on the full FIFO for 2^DROP_WIDTH+3 cycles.
    bus.debug_program_count               = 32'h9000_2000;
    bus.debug_register_file_write_enabled = 4'hF;
    bus.debug_register_file_write_address = 5'd10;
    bus.debug_register_file_write_data    = 32'h7;
    repeat ((1 << DROP_WIDTH) + 3) @(posedge clock);
    #1 bus.debug_register_file_write_enabled = 4'h0;
    check("sat_dropped", bus.dropped_count, 32'h0000_FFFF);
    check("sat_flag", bus.trace_overflow, 32'd1);
    check("sat_count", bus.trace_count, 32'd16);
    bus.overflow_clear = 1'b1;
    step();
    bus.overflow_clear = 1'b0;
    check("sat_clear", bus.dropped_count, 32'd0);

    // Drain to 7 entries, then asynchronous reset between edges.
    bus.trace_ready = 1'b1;
    repeat (9) step();
    bus.trace_ready = 1'b0;
    check("pre_reset_count", bus.trace_count, 32'd7);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid", bus.trace_valid, 32'd0);
    check("async_reset_count", bus.trace_count, 32'd0);
    sb_q.delete();
    #2 reset = 1'b0;
    step();
    capture(32'hDEAD_BEE0, 4'h3, 5'd17, 32'h0BAD_CAFE, 1'b1);
    check("post_reset_valid", bus.trace_valid, 32'd1);
    check("post_reset_count", bus.trace_count, 32'd1);
    check("post_reset_pc", bus.trace_program_count, 32'hDEAD_BEE0);
    check("post_reset_data", bus.trace_write_data, 32'h0BAD_CAFE);
    bus.trace_ready = 1'b1;
    step();
    bus.trace_ready = 1'b0;
    check("post_reset_drained", bus.trace_count, 32'd0);
    check("final_queue_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
